// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types for the sequential floating-point add/subtract unit.
// Holds the FSM state enum, status bit indices and the exponent bias helper.
package fpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        DONE
    } fpu_state_e;

    localparam int ST_ZERO      = 0;
    localparam int ST_INEXACT   = 1;
    localparam int ST_UNDERFLOW = 2;
    localparam int ST_OVERFLOW  = 3;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/fpu_addsub_seq_if.sv
// fpu_addsub_seq_if: operand handshake and result bundle of the FP add/sub unit.
// master drives operands, slave (the unit) returns result and status.
interface fpu_addsub_seq_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic              op_sub;
    logic [DATA_W-1:0] Op_A_in;
    logic [DATA_W-1:0] Op_B_in;
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic [3:0]        status_out;

    modport master (
        output in_valid, op_sub, Op_A_in, Op_B_in,
        input  in_ready, data_out, out_valid, status_out
    );

    modport slave (
        input  in_valid, op_sub, Op_A_in, Op_B_in,
        output in_ready, data_out, out_valid, status_out
    );
endinterface

// File: rtl/fpu_round.sv
// fpu_round: combinational rounding of a normalised mantissa with guard/round/sticky.
// FPU_ROUND_NEAREST_EN selects round-to-nearest-even, otherwise truncation.
module fpu_round #(
    parameter int EXP_W = 6,
    parameter int MAN_W = 25
) (
    input  logic [MAN_W+3:0]        man_i,
    input  logic signed [EXP_W+1:0] exp_i,
    output logic [MAN_W-1:0]        man_o,
    output logic signed [EXP_W+1:0] exp_o,
    output logic                    inexact_o
);
    logic             up;
    logic [MAN_W+1:0] sum;

    // increment decision plus renormalisation when the increment carries out
    always_comb begin
        inexact_o = |man_i[2:0];
`ifdef FPU_ROUND_NEAREST_EN
        up = man_i[2] & (man_i[1] | man_i[0] | man_i[3]);
`else
        up = 1'b0;
`endif
        sum = {1'b0, man_i[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, up};
        if (sum[MAN_W+1]) begin
            man_o = sum[MAN_W:1];
            exp_o = exp_i + (EXP_W+2)'(1);
        end else begin
            man_o = sum[MAN_W-1:0];
            exp_o = exp_i;
        end
    end
endmodule

// File: rtl/fpu_addsub_seq.sv
// fpu_addsub_seq: multi-cycle parametrised FP add/subtract with valid/ready input.
// Build option FPU_ROUND_NEAREST_EN: round-to-nearest-even instead of truncation.
module fpu_addsub_seq
    import fpu_pkg::*;
#(
    parameter int EXP_W = 6,
    parameter int MAN_W = 25
) (
    input logic             clock_100kHz,
    input logic             reset,
    fpu_addsub_seq_if.slave bus
);
    localparam int DATA_W = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 4;
    localparam int SW = MAN_W + 5;
    localparam int EW = EXP_W + 2;
    localparam logic [EXP_W-1:0] FLUSH_D = EXP_W'(MAN_W + 2);
    localparam logic [EXP_W-1:0] E_ONE = EXP_W'(1);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EZERO = '0;
    localparam logic signed [EW-1:0] ER_ONE = EW'(1);

    fpu_state_e state_q, state_d;
    logic sa_q, sa_d, sb_q, sb_d, sr_q, sr_d;
    logic [EXP_W-1:0] ea_q, ea_d, eb_q, eb_d, diff;
    logic [MW-1:0] ma_q, ma_d, mb_q, mb_d;
    logic [SW-1:0] sum_q, sum_d;
    logic signed [EW-1:0] er_q, er_d;
    logic zero_q, zero_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [3:0] stat_q, stat_d;

    logic [MAN_W-1:0] rnd_man;
    logic signed [EW-1:0] rnd_exp;
    logic rnd_inexact;

    // {hidden, mantissa, g, r, s}; a zero exponent field flushes to zero
    function automatic logic [MW-1:0] hid(input logic [EXP_W-1:0] e,
                                          input logic [MAN_W-1:0] m);
        return (e == '0) ? '0 : {1'b1, m, 3'b000};
    endfunction

    // one-bit right shift that folds the lost bits into sticky
    function automatic logic [MW-1:0] shr(input logic [MW-1:0] m);
        return {1'b0, m[MW-1:2], m[1] | m[0]};
    endfunction

    fpu_round #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_round (
        .man_i    (sum_q[MW-1:0]),
        .exp_i    (er_q),
        .man_o    (rnd_man),
        .exp_o    (rnd_exp),
        .inexact_o(rnd_inexact)
    );

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.data_out   = dout_q;
    assign bus.status_out = stat_q;

    // state register and datapath registers; reset aborts any operation
    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            sr_q    <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            sum_q   <= '0;
            er_q    <= '0;
            zero_q  <= 1'b0;
            dout_q  <= '0;
            stat_q  <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            sum_q   <= sum_d;
            er_q    <= er_d;
            zero_q  <= zero_d;
            dout_q  <= dout_d;
            stat_q  <= stat_d;
        end
    end

    // next-state and datapath step for each FSM phase
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        sum_d   = sum_q;
        er_d    = er_q;
        zero_d  = zero_q;
        dout_d  = dout_q;
        stat_d  = stat_q;
        diff    = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = ALIGN;
                    sa_d    = bus.Op_A_in[DATA_W-1];
                    sb_d    = bus.Op_B_in[DATA_W-1] ^ bus.op_sub;
                    ea_d    = bus.Op_A_in[DATA_W-2 -: EXP_W];
                    eb_d    = bus.Op_B_in[DATA_W-2 -: EXP_W];
                    ma_d    = hid(bus.Op_A_in[DATA_W-2 -: EXP_W],
                                  bus.Op_A_in[MAN_W-1:0]);
                    mb_d    = hid(bus.Op_B_in[DATA_W-2 -: EXP_W],
                                  bus.Op_B_in[MAN_W-1:0]);
                    zero_d  = 1'b0;
                end
            end
            ALIGN: begin
                if (ea_q == eb_q) begin
                    state_d = ADD;
                end else if (ea_q > eb_q) begin
                    diff = ea_q - eb_q;
                    if (diff > FLUSH_D) begin
                        mb_d    = {{(MW-1){1'b0}}, |mb_q};
                        eb_d    = ea_q;
                        state_d = ADD;
                    end else begin
                        mb_d = shr(mb_q);
                        eb_d = eb_q + E_ONE;
                        if (diff == E_ONE) state_d = ADD;
                    end
                end else begin
                    diff = eb_q - ea_q;
                    if (diff > FLUSH_D) begin
                        ma_d    = {{(MW-1){1'b0}}, |ma_q};
                        ea_d    = eb_q;
                        state_d = ADD;
                    end else begin
                        ma_d = shr(ma_q);
                        ea_d = ea_q + E_ONE;
                        if (diff == E_ONE) state_d = ADD;
                    end
                end
            end
            ADD: begin
                state_d = NORM;
                er_d    = {2'b00, ea_q};
                if (sa_q == sb_q) begin
                    sum_d = {1'b0, ma_q} + {1'b0, mb_q};
                    sr_d  = sa_q;
                end else if (ma_q >= mb_q) begin
                    sum_d = {1'b0, ma_q - mb_q};
                    sr_d  = sa_q;
                end else begin
                    sum_d = {1'b0, mb_q - ma_q};
                    sr_d  = sb_q;
                end
            end
            NORM: begin
                if (sum_q == '0) begin
                    zero_d  = 1'b1;
                    state_d = ROUND;
                end else if (sum_q[SW-1]) begin
                    sum_d   = {1'b0, sum_q[SW-1:2], sum_q[1] | sum_q[0]};
                    er_d    = er_q + ER_ONE;
                    state_d = ROUND;
                end else if (sum_q[SW-2]) begin
                    state_d = ROUND;
                end else begin
                    sum_d = {sum_q[SW-2:0], 1'b0};
                    er_d  = er_q - ER_ONE;
                end
            end
            ROUND: begin
                state_d = DONE;
                stat_d  = '0;
                if (zero_q) begin
                    dout_d          = '0;
                    stat_d[ST_ZERO] = 1'b1;
                end else if (rnd_exp > EMAX) begin
                    dout_d              = {sr_q, {(DATA_W-1){1'b1}}};
                    stat_d[ST_OVERFLOW] = 1'b1;
                    stat_d[ST_INEXACT]  = 1'b1;
                end else if (rnd_exp <= EZERO) begin
                    dout_d               = {sr_q, {(DATA_W-1){1'b0}}};
                    stat_d[ST_UNDERFLOW] = 1'b1;
                    stat_d[ST_INEXACT]   = 1'b1;
                    stat_d[ST_ZERO]      = 1'b1;
                end else begin
                    dout_d             = {sr_q, rnd_exp[EXP_W-1:0], rnd_man};
                    stat_d[ST_INEXACT] = rnd_inexact;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_fpu_addsub_seq.sv
// tb_fpu_addsub_seq: directed and random checks of fpu_addsub_seq (EXP_W=6, MAN_W=25)
// against an exact-arithmetic reference; honours FPU_ROUND_NEAREST_EN.
module tb_fpu_addsub_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    fpu_addsub_seq_if #(.DATA_W(32)) bus ();

    fpu_addsub_seq #(
        .EXP_W(6),
        .MAN_W(25)
    ) dut (
        .clock_100kHz(clk),
        .reset       (rst_n),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // exact value of A +/- B, then rounded, range-checked and packed
    task automatic ref_model(input logic [31:0] a, input logic [31:0] b,
                             input logic sub, output logic [31:0] res,
                             output logic [3:0] st);
        logic sa, sb, s, inx, up;
        int ea, eb, emin, p, e, sh;
        logic [127:0] ia, ib, mag, keep, rem, half;
        sa = a[31];
        sb = b[31] ^ sub;
        ea = int'(a[30:25]);
        eb = int'(b[30:25]);
        ia = (ea == 0) ? 128'd0 : {102'd0, 1'b1, a[24:0]};
        ib = (eb == 0) ? 128'd0 : {102'd0, 1'b1, b[24:0]};
        if (ea == 0) ea = eb;
        if (eb == 0) eb = ea;
        emin = (ea < eb) ? ea : eb;
        ia = ia << (ea - emin);
        ib = ib << (eb - emin);
        if (sa == sb) begin
            mag = ia + ib;
            s = sa;
        end else if (ia >= ib) begin
            mag = ia - ib;
            s = sa;
        end else begin
            mag = ib - ia;
            s = sb;
        end
        if (mag == 128'd0) begin
            res = 32'h0;
            st = 4'b0001;
            return;
        end
        p = 0;
        for (int i = 0; i < 128; i++) if (mag[i]) p = i;
        e = emin + p - 25;
        inx = 1'b0;
        if (p > 25) begin
            sh = p - 25;
            keep = mag >> sh;
            rem = mag & ((128'd1 << sh) - 128'd1);
            half = 128'd1 << (sh - 1);
            inx = (rem != 128'd0);
`ifdef FPU_ROUND_NEAREST_EN
            up = (rem > half) || ((rem == half) && keep[0]);
`else
            up = 1'b0;
`endif
            keep = keep + {127'd0, up};
            if (keep[26]) begin
                keep = keep >> 1;
                e++;
            end
        end else begin
            keep = mag << (25 - p);
        end
        if (e > 63) begin
            res = {s, 31'h7FFFFFFF};
            st = 4'b1010;
        end else if (e <= 0) begin
            res = {s, 31'h0};
            st = 4'b0111;
        end else begin
            res = {s, 6'(e), keep[24:0]};
            st = {2'b00, inx, 1'b0};
        end
    endtask

    // called at a falling edge; returns at the falling edge showing out_valid
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic sub, output logic [31:0] res,
                         output logic [3:0] st, output int lat);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        bus.Op_A_in = a;
        bus.Op_B_in = b;
        bus.op_sub = sub;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("result_strobe", {31'd0, bus.out_valid}, 32'd1);
        res = bus.data_out;
        st = bus.status_out;
    endtask

    logic [31:0] a, b, r, mr, e_stk, e_tie0, e_tie1;
    logic [3:0] s, ms;
    logic sub;
    int lat, cnt, acc, nres, last, cyc;

    initial begin
`ifdef FPU_ROUND_NEAREST_EN
        e_stk = 32'h3E000001;
        e_tie1 = 32'h3E000002;
`else
        e_stk = 32'h3E000000;
        e_tie1 = 32'h3E000001;
`endif
        e_tie0 = 32'h3E000000;
        bus.in_valid = 1'b0;
        bus.op_sub = 1'b0;
        bus.Op_A_in = '0;
        bus.Op_B_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_data", bus.data_out, 32'h0);
        chk("rst_status", {28'd0, bus.status_out}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(32'h3E000000, 32'h40000000, 1'b0, r, s, lat);
        chk("one_plus_two", r, 32'h41000000);
        chk("one_plus_two_st", {28'd0, s}, 32'h0);
        chk("min_latency", lat, 5);

        do_op(32'h3E000000, 32'h3E000000, 1'b1, r, s, lat);
        chk("cancel", r, 32'h0);
        chk("cancel_st", {28'd0, s}, 32'h1);
        @(negedge clk);
        chk("single_pulse", {31'd0, bus.out_valid}, 32'd0);
        chk("ready_after_done", {31'd0, bus.in_ready}, 32'd1);

        do_op(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, r, s, lat);
        chk("overflow", r, 32'h7FFFFFFF);
        chk("overflow_st", {28'd0, s}, 32'hA);

        do_op(32'h40000000, 32'h02000000, 1'b0, r, s, lat);
        chk("flush_sticky", r, 32'h40000000);
        chk("flush_sticky_st", {28'd0, s}, 32'h2);
        chk("flush_latency", lat, 5);

        do_op(32'h3E000000, 32'h0A000002, 1'b0, r, s, lat);
        chk("grs_above_half", r, e_stk);
        chk("grs_above_half_st", {28'd0, s}, 32'h2);
        do_op(32'h3E000000, 32'h0A000000, 1'b0, r, s, lat);
        chk("tie_even", r, e_tie0);
        do_op(32'h3E000001, 32'h0A000000, 1'b0, r, s, lat);
        chk("tie_odd", r, e_tie1);
        do_op(32'h00000000, 32'hC1000000, 1'b1, r, s, lat);
        chk("zero_pass", r, 32'h41000000);
        chk("zero_pass_st", {28'd0, s}, 32'h0);

        // long NORM: cancellation down to the last mantissa bit, reset midway
        @(negedge clk);
        bus.Op_A_in = 32'h3E000001;
        bus.Op_B_in = 32'h3E000000;
        bus.op_sub = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("abort_data", bus.data_out, 32'h0);
        chk("abort_status", {28'd0, bus.status_out}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) cnt++;
        end
        chk("abort_no_result", cnt, 0);
        do_op(32'h3E000000, 32'h40000000, 1'b0, r, s, lat);
        chk("after_abort", r, 32'h41000000);

        // in_valid held high: one accept per result, fixed 6-cycle spacing
        @(negedge clk);
        bus.Op_A_in = 32'h3E000000;
        bus.Op_B_in = 32'h40000000;
        bus.op_sub = 1'b0;
        bus.in_valid = 1'b1;
        acc = 0;
        nres = 0;
        last = -1;
        cyc = 0;
        while (nres < 3 && cyc < 100) begin
            if (bus.in_ready === 1'b1) begin
                if (last >= 0) chk("b2b_gap", cyc - last, 6);
                last = cyc;
                acc++;
            end
            if (bus.out_valid === 1'b1) begin
                nres++;
                chk("b2b_data", bus.data_out, 32'h41000000);
                chk("b2b_busy", {31'd0, bus.in_ready}, 32'd0);
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("b2b_results", nres, 3);
        chk("b2b_accepts", acc, 3);

        for (int i = 0; i < 160; i++) begin
            a = $urandom;
            b = $urandom;
            sub = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 6))
                1: b[30:25] = a[30:25];
                2: b[30:25] = a[30:25] + 6'($urandom_range(0, 3));
                3: b[30:0] = a[30:0];
                4: b[30:25] = 6'd0;
                5: begin
                    a[30:25] = 6'h3F;
                    b[30:25] = 6'h3F - 6'($urandom_range(0, 1));
                end
                6: begin
                    a[30:25] = 6'($urandom_range(1, 3));
                    b[30:0] = a[30:0] ^ 31'($urandom_range(1, 255));
                    sub = b[31] ^ ~a[31];
                end
                default: ;
            endcase
            ref_model(a, b, sub, mr, ms);
            do_op(a, b, sub, r, s, lat);
            chk("rnd_data", r, mr);
            chk("rnd_status", {28'd0, s}, {28'd0, ms});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
